rmgmt_decode_arbiter: RTL and testbench
=======================================

# rmgmt_decode_arbiter

Arbitrates decode-stage instruction claims from up to N_EXT RISC-MGMT extensions. It picks one claiming extension per instruction and locks that grant while the decode stage is held. It forwards the winner's register selects to the register file and sequences multi-cycle bubble requests into a decode stall. It sits between the decode stage and the per-extension decode interfaces.

## Interface
- N_EXT, 4: number of extensions; range 2..8.
- BUBBLE_TIMEOUT, 64: maximum consecutive bubble cycles before forced release (watchdog builds only).
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- insn_valid  in  1  decode stage holds a valid instruction.
- pipe_stall  in  1  downstream stall; the decode instruction is held this cycle.
- ext_claim  in  N_EXT  per-extension insn_claim.
- ext_bubble_req  in  N_EXT  per-extension bubble_req.
- ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d  in  N_EXT x 5  per-extension register selects.
- claim_valid  out  1  an extension owns the current instruction.
- claim_id  out  $clog2(N_EXT)  index of the owning extension.
- rsel_s_0, rsel_s_1, rsel_d  out  5 each  selects of the owner; 0 when claim_valid=0.
- decode_stall  out  1  the decode stage must insert a bubble.
- multi_claim_err  out  1  registered one-cycle pulse; more than one extension claimed.
- timeout_err  out  1  registered one-cycle pulse; the watchdog fired.

## Operation
- The FSM has three states: IDLE, GRANT and BUBBLE. It also holds a lock register (claim_id width) and a bubble counter ($clog2(BUBBLE_TIMEOUT) bits).
- Winner selection is fixed priority: the lowest asserted index of ext_claim, evaluated only when insn_valid=1.
- IDLE:
  - Outputs are driven combinationally from the winner.
  - If there is a winner and ext_bubble_req[winner]=1: lock <= winner, go to BUBBLE.
  - Else if there is a winner and pipe_stall=1: lock <= winner, go to GRANT.
  - Otherwise stay in IDLE; a grant lasts a single cycle.
- GRANT:
  - Outputs are driven from lock. claim_valid=1.
  - Claims from other extensions are ignored.
  - If ext_bubble_req[lock]=1, go to BUBBLE; else if pipe_stall=0, go to IDLE.
- BUBBLE:
  - Outputs are driven from lock. claim_valid=1 and decode_stall=1.
  - The counter increments every cycle.
  - When ext_bubble_req[lock] drops: clear the counter, then go to GRANT if pipe_stall=1, else to IDLE.
- decode_stall=0 in IDLE and GRANT, except that in IDLE it is asserted combinationally in the same cycle a winner raises bubble_req.
- multi_claim_err is registered from "popcount(ext_claim)>1 and insn_valid and state==IDLE". It is never raised while a lock is held.
- A claim with insn_valid=0 is ignored entirely.

## Timing
- Claim-to-grant latency is 0 cycles (combinational in IDLE). Lock capture takes 1 cycle.
- Error pulses lag their cause by exactly 1 cycle and last 1 cycle.
- Reset: state=IDLE, lock=0, counter=0, error pulses=0. Resulting outputs: claim_valid=0, claim_id=0, rsel_*=0, decode_stall=0.
- RST asserted mid-BUBBLE or mid-GRANT forces IDLE at the next edge. No error pulse is generated for the abandoned instruction.
- If the bubble request drops and pipe_stall rises in the same cycle, the FSM goes BUBBLE to GRANT.
- If the owner drops its claim while locked, the lock persists until it is released by the transition rules above.

## Configuration
- RMGMT_ARB_WATCHDOG_EN defined:
  - When the counter reaches BUBBLE_TIMEOUT-1 while in BUBBLE, the next edge forces IDLE, clears lock and counter, and pulses timeout_err.
  - decode_stall drops that same edge.
- Not defined:
  - The counter is not built, BUBBLE persists indefinitely, and timeout_err is tied to 0.

## Structure
- The shared rmgmt package holds:
  - the enum rmgmt_arb_state_t {IDLE, GRANT, BUBBLE}
  - the constants RMGMT_MAX_EXT=8 and RMGMT_RSEL_W=5
  - the existing word_t
- One sub-module, rmgmt_prio_enc: a combinational lowest-index encoder (N_EXT request bits to index and valid) plus a popcount>1 flag.

## Test plan
- Single claim: insn_valid=1, ext_claim=4'b0100, no stall. Response: claim_valid=1 and claim_id=2 the same cycle; rsel outputs equal ext 2's selects; state stays IDLE.
- Multi-claim: ext_claim=4'b0110. Response: claim_id=1; multi_claim_err=1 on the next cycle only.
- Bubble lock: ext 3 claims with bubble_req held for 5 cycles while ext 0 also claims in cycles 2-4. Response: claim_id=3 and decode_stall=1 for 5 cycles; ext 0 is never granted; multi_claim_err is not asserted after cycle 1.
- Stall hold: claim by ext 1 with pipe_stall=1 for 3 cycles. Response: GRANT with claim_id=1 held for all 3 cycles; IDLE after pipe_stall drops.
- Watchdog (macro on, BUBBLE_TIMEOUT=8): ext 0 holds bubble_req indefinitely. Response: decode_stall is high for 8 cycles; timeout_err pulses; then IDLE with claim_valid as re-evaluated.
- Reset mid-bubble: RST=1 during BUBBLE. Response: next cycle all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/rmgmt_decode_arbiter_pkg.sv
// Shared RISC-MGMT types and constants used by the decode-stage claim arbiter.
package rmgmt_decode_arbiter_pkg;

    localparam int RMGMT_MAX_EXT = 8;
    localparam int RMGMT_RSEL_W  = 5;

    typedef logic [31:0]             word_t;
    typedef logic [RMGMT_RSEL_W-1:0] rsel_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUBBLE
    } rmgmt_arb_state_t;

endpackage

// File: rtl/rmgmt_decode_arbiter_if.sv
// Decode-stage <-> extension-claim bundle; the arbiter sits on the slave modport.
interface rmgmt_decode_arbiter_if
    import rmgmt_decode_arbiter_pkg::*;
#(
    parameter int N_EXT = 4
);
    localparam int ID_W = $clog2(N_EXT);

    logic                  insn_valid;
    logic                  pipe_stall;
    logic [N_EXT-1:0]      ext_claim;
    logic [N_EXT-1:0]      ext_bubble_req;
    rsel_t [N_EXT-1:0]     ext_rsel_s_0;
    rsel_t [N_EXT-1:0]     ext_rsel_s_1;
    rsel_t [N_EXT-1:0]     ext_rsel_d;

    logic                  claim_valid;
    logic [ID_W-1:0]       claim_id;
    rsel_t                 rsel_s_0;
    rsel_t                 rsel_s_1;
    rsel_t                 rsel_d;
    logic                  decode_stall;
    logic                  multi_claim_err;
    logic                  timeout_err;

    modport master (
        output insn_valid, pipe_stall, ext_claim, ext_bubble_req,
               ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d,
        input  claim_valid, claim_id, rsel_s_0, rsel_s_1, rsel_d,
               decode_stall, multi_claim_err, timeout_err
    );

    modport slave (
        input  insn_valid, pipe_stall, ext_claim, ext_bubble_req,
               ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d,
        output claim_valid, claim_id, rsel_s_0, rsel_s_1, rsel_d,
               decode_stall, multi_claim_err, timeout_err
    );

endinterface

// File: rtl/rmgmt_decode_arbiter_prio_enc.sv
// Lowest-index priority encoder with a "more than one request" flag.
module rmgmt_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] idx,
    output logic            valid,
    output logic            multi
);

    // Scanning from the top lets the lowest set bit overwrite the rest.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

    assign multi = |(req & (req - 1'b1));

endmodule

// File: rtl/rmgmt_decode_arbiter.sv
// Decode-stage claim arbiter: fixed-priority grant, lock while held, bubble sequencing.
// Optional bubble watchdog enabled by defining RMGMT_ARB_WATCHDOG_EN.
module rmgmt_decode_arbiter
    import rmgmt_decode_arbiter_pkg::*;
#(
    parameter int N_EXT          = 4,
    parameter int BUBBLE_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    rmgmt_decode_arbiter_if.slave        bus
);

    localparam int ID_W = $clog2(N_EXT);

    if (N_EXT < 2 || N_EXT > RMGMT_MAX_EXT || BUBBLE_TIMEOUT < 2) begin : g_bad_cfg
        $error("rmgmt_decode_arbiter: unsupported N_EXT or BUBBLE_TIMEOUT");
    end

    rmgmt_arb_state_t  state;
    logic [ID_W-1:0]   lock;
    logic              multi_err_q;
    logic              timeout_err_q;

    logic [N_EXT-1:0]  live_claim;
    logic [ID_W-1:0]   win_id;
    logic              win_valid;
    logic              win_multi;
    logic              win_bubble;
    logic              lock_bubble;
    logic              wd_fire;

    logic              owner_valid;
    logic [ID_W-1:0]   owner_id;
    logic              stall;

    assign live_claim = bus.insn_valid ? bus.ext_claim : '0;

    rmgmt_prio_enc #(
        .N    (N_EXT),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (live_claim),
        .idx   (win_id),
        .valid (win_valid),
        .multi (win_multi)
    );

    assign win_bubble  = win_valid && bus.ext_bubble_req[win_id];
    assign lock_bubble = bus.ext_bubble_req[lock];

`ifdef RMGMT_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(BUBBLE_TIMEOUT);

    logic [CNT_W-1:0] bubble_cnt;

    assign wd_fire = (state == BUBBLE) && (bubble_cnt == CNT_W'(BUBBLE_TIMEOUT - 1));

    // Counts consecutive cycles the owner keeps requesting a bubble; idle at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (state == BUBBLE && lock_bubble && !wd_fire) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end else begin
            bubble_cnt <= '0;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // In IDLE the grant is combinational from the encoder; once locked the owner is frozen.
    always_comb begin
        owner_valid = 1'b0;
        owner_id    = '0;
        stall       = 1'b0;
        unique case (state)
            IDLE: begin
                owner_valid = win_valid;
                owner_id    = win_id;
                stall       = win_bubble;
            end
            GRANT: begin
                owner_valid = 1'b1;
                owner_id    = lock;
            end
            BUBBLE: begin
                owner_valid = 1'b1;
                owner_id    = lock;
                stall       = 1'b1;
            end
            default: begin
                owner_valid = 1'b0;
            end
        endcase
    end

    assign bus.claim_valid     = owner_valid;
    assign bus.claim_id        = owner_id;
    assign bus.rsel_s_0        = owner_valid ? bus.ext_rsel_s_0[owner_id] : '0;
    assign bus.rsel_s_1        = owner_valid ? bus.ext_rsel_s_1[owner_id] : '0;
    assign bus.rsel_d          = owner_valid ? bus.ext_rsel_d[owner_id]   : '0;
    assign bus.decode_stall    = stall;
    assign bus.multi_claim_err = multi_err_q;
    assign bus.timeout_err     = timeout_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lock          <= '0;
            multi_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            multi_err_q   <= (state == IDLE) && win_multi;
            timeout_err_q <= wd_fire;
            unique case (state)
                IDLE: begin
                    if (win_bubble) begin
                        lock  <= win_id;
                        state <= BUBBLE;
                    end else if (win_valid && bus.pipe_stall) begin
                        lock  <= win_id;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (lock_bubble) begin
                        state <= BUBBLE;
                    end else if (!bus.pipe_stall) begin
                        state <= IDLE;
                    end
                end
                BUBBLE: begin
                    // The watchdog outranks a bubble release landing on the same edge.
                    if (wd_fire) begin
                        lock  <= '0;
                        state <= IDLE;
                    end else if (!lock_bubble) begin
                        state <= bus.pipe_stall ? GRANT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmgmt_decode_arbiter.sv
// Self-checking bench for rmgmt_decode_arbiter; honours RMGMT_ARB_WATCHDOG_EN (timeout 8).
module tb_rmgmt_decode_arbiter;
    import rmgmt_decode_arbiter_pkg::*;

    localparam int N_EXT = 4;
`ifdef RMGMT_ARB_WATCHDOG_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 64;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rmgmt_decode_arbiter_if #(.N_EXT(N_EXT)) bus ();

    rmgmt_decode_arbiter #(
        .N_EXT          (N_EXT),
        .BUBBLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at the falling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [3:0] c,
                                 input logic [3:0] b, input logic r);
        @(posedge clk);
        #1;
        rst                = r;
        bus.insn_valid     = v;
        bus.pipe_stall     = s;
        bus.ext_claim      = c;
        bus.ext_bubble_req = b;
        @(negedge clk);
    endtask

    // Reference model: who owns the decode slot and whether it is bubbling.
    int   owner;
    bit   bubbling;
    int   bub_cycles;
    bit   model_ok = 1'b0;
    logic exp_mce;
    logic exp_to;
    int   win;
    int   claimers;
    int   e_cv;
    int   e_id;
    int   e_ds;

    always @(negedge clk) begin
        win      = -1;
        claimers = 0;
        if (bus.insn_valid === 1'b1) begin
            for (int i = 0; i < N_EXT; i++) begin
                if (bus.ext_claim[i] === 1'b1) begin
                    claimers++;
                    if (win < 0) win = i;
                end
            end
        end
        if (model_ok) begin
            if (owner < 0) begin
                e_cv = (win >= 0) ? 1 : 0;
                e_id = (win >= 0) ? win : 0;
                e_ds = (win >= 0 && bus.ext_bubble_req[win] === 1'b1) ? 1 : 0;
            end else begin
                e_cv = 1;
                e_id = owner;
                e_ds = bubbling ? 1 : 0;
            end
            checkOutput("mdl.claim_valid", bus.claim_valid, e_cv);
            checkOutput("mdl.claim_id", bus.claim_id, e_id);
            checkOutput("mdl.rsel_s_0", bus.rsel_s_0, e_cv ? e_id * 3 + 1 : 0);
            checkOutput("mdl.rsel_s_1", bus.rsel_s_1, e_cv ? e_id * 5 + 2 : 0);
            checkOutput("mdl.rsel_d", bus.rsel_d, e_cv ? e_id * 7 + 3 : 0);
            checkOutput("mdl.decode_stall", bus.decode_stall, e_ds);
            checkOutput("mdl.multi_claim_err", bus.multi_claim_err, exp_mce);
            checkOutput("mdl.timeout_err", bus.timeout_err, exp_to);
        end
        if (rst) begin
            owner      = -1;
            bubbling   = 1'b0;
            bub_cycles = 0;
            exp_mce    = 1'b0;
            exp_to     = 1'b0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            exp_mce = (owner < 0) && (claimers > 1);
            exp_to  = 1'b0;
            if (owner < 0) begin
                if (win >= 0 && bus.ext_bubble_req[win] === 1'b1) begin
                    owner    = win;
                    bubbling = 1'b1;
                end else if (win >= 0 && bus.pipe_stall === 1'b1) begin
                    owner = win;
                end
                bub_cycles = 0;
            end else if (!bubbling) begin
                if (bus.ext_bubble_req[owner] === 1'b1) bubbling = 1'b1;
                else if (bus.pipe_stall !== 1'b1) owner = -1;
            end else begin
                bub_cycles++;
`ifdef RMGMT_ARB_WATCHDOG_EN
                if (bub_cycles == TIMEOUT) begin
                    owner      = -1;
                    bubbling   = 1'b0;
                    bub_cycles = 0;
                    exp_to     = 1'b1;
                end else
`endif
                if (bus.ext_bubble_req[owner] !== 1'b1) begin
                    bubbling   = 1'b0;
                    bub_cycles = 0;
                    if (bus.pipe_stall !== 1'b1) owner = -1;
                end
            end
        end
    end

    initial begin
        bus.insn_valid     = 1'b0;
        bus.pipe_stall     = 1'b0;
        bus.ext_claim      = '0;
        bus.ext_bubble_req = '0;
        for (int i = 0; i < N_EXT; i++) begin
            bus.ext_rsel_s_0[i] = rsel_t'(i * 3 + 1);
            bus.ext_rsel_s_1[i] = rsel_t'(i * 5 + 2);
            bus.ext_rsel_d[i]   = rsel_t'(i * 7 + 3);
        end

        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        checkOutput("lit.reset.claim_valid", bus.claim_valid, 0);
        checkOutput("lit.reset.claim_id", bus.claim_id, 0);
        checkOutput("lit.reset.rsel_d", bus.rsel_d, 0);
        checkOutput("lit.reset.decode_stall", bus.decode_stall, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // single claim by ext 2
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
        checkOutput("lit.single.claim_valid", bus.claim_valid, 1);
        checkOutput("lit.single.claim_id", bus.claim_id, 2);
        checkOutput("lit.single.rsel_s_0", bus.rsel_s_0, 7);
        checkOutput("lit.single.rsel_s_1", bus.rsel_s_1, 12);
        checkOutput("lit.single.rsel_d", bus.rsel_d, 17);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.single.released", bus.claim_valid, 0);

        // claims without insn_valid are ignored
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
        checkOutput("lit.novalid.claim_valid", bus.claim_valid, 0);
        checkOutput("lit.novalid.decode_stall", bus.decode_stall, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.novalid.multi_err", bus.multi_claim_err, 0);

        // multi-claim: ext 1 wins, error pulse next cycle only
        applyStimulus(1'b1, 1'b0, 4'b0110, 4'b0000, 1'b0);
        checkOutput("lit.multi.claim_id", bus.claim_id, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.multi.err_pulse", bus.multi_claim_err, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.multi.err_clear", bus.multi_claim_err, 0);

        // bubble lock by ext 3 while ext 0 also claims
        applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0);
        checkOutput("lit.bubble.c1.claim_id", bus.claim_id, 3);
        checkOutput("lit.bubble.c1.stall", bus.decode_stall, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b1001, 4'b1000, 1'b0);
            checkOutput("lit.bubble.claim_id", bus.claim_id, 3);
            checkOutput("lit.bubble.stall", bus.decode_stall, 1);
            checkOutput("lit.bubble.multi_err", bus.multi_claim_err, 0);
        end
        applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.bubble.last.stall", bus.decode_stall, 1);
        checkOutput("lit.bubble.last.rsel_d", bus.rsel_d, 24);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.bubble.done", bus.claim_valid, 0);

        // stall hold by ext 1; owner drops its claim on the last held cycle
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0);
            checkOutput("lit.stall.claim_id", bus.claim_id, 1);
            checkOutput("lit.stall.decode_stall", bus.decode_stall, 0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.stall.lock_persists", bus.claim_valid, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.stall.idle", bus.claim_valid, 0);

        // bubble release together with stall goes to GRANT; other claimers ignored
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        checkOutput("lit.b2g.claim_id", bus.claim_id, 2);
        checkOutput("lit.b2g.decode_stall", bus.decode_stall, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.b2g.idle", bus.claim_valid, 0);

        // GRANT then bubble request from the owner
        applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0);
        checkOutput("lit.g2b.grant_stall", bus.decode_stall, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.g2b.bubble_stall", bus.decode_stall, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

`ifdef RMGMT_ARB_WATCHDOG_EN
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0);
        for (int k = 0; k < TIMEOUT; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0);
            checkOutput("lit.wd.stall", bus.decode_stall, 1);
            checkOutput("lit.wd.no_timeout", bus.timeout_err, 0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        checkOutput("lit.wd.timeout_pulse", bus.timeout_err, 1);
        checkOutput("lit.wd.reeval_valid", bus.claim_valid, 1);
        checkOutput("lit.wd.stall_dropped", bus.decode_stall, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.wd.timeout_clear", bus.timeout_err, 0);
`else
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0);
            checkOutput("lit.nowd.stall", bus.decode_stall, 1);
        end
        checkOutput("lit.nowd.timeout", bus.timeout_err, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.nowd.idle", bus.claim_valid, 0);
`endif

        // reset in the middle of a bubble
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0110, 4'b0010, 1'b1);
        checkOutput("lit.rst.pre_stall", bus.decode_stall, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lit.rst.claim_valid", bus.claim_valid, 0);
        checkOutput("lit.rst.claim_id", bus.claim_id, 0);
        checkOutput("lit.rst.decode_stall", bus.decode_stall, 0);
        checkOutput("lit.rst.rsel_s_0", bus.rsel_s_0, 0);
        checkOutput("lit.rst.multi_err", bus.multi_claim_err, 0);
        checkOutput("lit.rst.timeout_err", bus.timeout_err, 0);

        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
